// File: rtl/axi_stream_if_m_reg_connector_if.sv
// axi_stream_if: one AXI-Stream channel carrying a data beat plus size/src/dst sideband.
// Latency: none, this is a bundle of wires.
// Backpressure: ready flows from the slave side back to the master side.
//
// Ports (modport master drives the payload, modport slave drives ready):
//   valid, data[DATA_W], keep[DATA_W/8], last, user_size/src/dst[USER_W]  master -> slave
//   ready                                                                slave  -> master
interface axi_stream_if #(
  parameter int DATA_W = 512,
  parameter int USER_W = 16
);
  logic                  valid;
  logic [DATA_W-1:0]     data;
  logic [DATA_W/8-1:0]   keep;
  logic                  last;
  logic [USER_W-1:0]     user_size;
  logic [USER_W-1:0]     user_src;
  logic [USER_W-1:0]     user_dst;
  logic                  ready;

  modport master (
    output valid, data, keep, last, user_size, user_src, user_dst,
    input  ready
  );

  modport slave (
    input  valid, data, keep, last, user_size, user_src, user_dst,
    output ready
  );
endinterface

// File: rtl/axi_stream_if_m_reg_connector.sv
// Egress connector: array of axi_stream_if slaves -> flat concatenated AXI-Stream master vectors.
// Latency: 1 cycle per channel through a two-entry skid buffer (REG_EN=1), 0 cycles when REG_EN=0.
// Backpressure: s.ready is a flop equal to "skid empty"; one extra beat is absorbed after m_tready drops.
//
// Ports:
//   axis_aclk, axis_rst          clock and asynchronous active-high reset
//   s_axis[COUNTS]               per-channel input streams (slave modport)
//   m_axis_t*                    flat outputs, channel i in slice i of each vector
//   m_axis_tready[COUNTS]        per-channel downstream ready
//   pkt_cnt[CNT_W*COUNTS]        delivered-packet counters (beats with tlast), wrapping
module axi_stream_if_m_reg_connector #(
  parameter int COUNTS = 1,
  parameter int DATA_W = 512,
  parameter int USER_W = 16,
  parameter int REG_EN = 1,
  parameter int CNT_W  = 32
) (
  input  logic                         axis_aclk,
  input  logic                         axis_rst,
  axi_stream_if.slave                  s_axis [COUNTS],
  output logic [COUNTS-1:0]            m_axis_tvalid,
  output logic [DATA_W*COUNTS-1:0]     m_axis_tdata,
  output logic [DATA_W/8*COUNTS-1:0]   m_axis_tkeep,
  output logic [COUNTS-1:0]            m_axis_tlast,
  output logic [USER_W*COUNTS-1:0]     m_axis_tuser_size,
  output logic [USER_W*COUNTS-1:0]     m_axis_tuser_src,
  output logic [USER_W*COUNTS-1:0]     m_axis_tuser_dst,
  input  logic [COUNTS-1:0]            m_axis_tready,
  output logic [CNT_W*COUNTS-1:0]      pkt_cnt
);

  localparam int KEEP_W = DATA_W / 8;

  // Full payload of one beat; moved between registers as a single unit so
  // no field can ever be split from its siblings.
  typedef struct packed {
    logic [DATA_W-1:0] dat;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [USER_W-1:0] size;
    logic [USER_W-1:0] src;
    logic [USER_W-1:0] dst;
  } beat_t;

  // EMPTY: nothing held. ONE: main holds a beat. FULL: main and skid both hold beats.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  for (genvar i = 0; i < COUNTS; i++) begin : g_ch
    beat_t in_dat;
    beat_t out_dat;
    logic  in_vld;
    logic  in_rdy;
    logic  out_vld;
    logic  out_rdy;
    logic  dlv_vld;
    logic [CNT_W-1:0] cnt_q;

    assign in_vld = s_axis[i].valid;
    assign in_dat = {s_axis[i].data, s_axis[i].keep, s_axis[i].last,
                     s_axis[i].user_size, s_axis[i].user_src, s_axis[i].user_dst};
    assign s_axis[i].ready = in_rdy;
    assign out_rdy = m_axis_tready[i];

    if (REG_EN != 0) begin : g_reg
      state_t state_q;
      state_t state_nxt;
      logic   rdy_q;
      logic   rdy_nxt;
      beat_t  main_q;
      beat_t  skid_q;
      logic   acc;
      logic   dlv;
      logic   load_main;
      logic   load_skid;
      logic   move_skid;

      // rdy_q (not state_q) gates acceptance: it is low during reset even
      // though the state is EMPTY, and only rises on the first edge after.
      assign acc = in_vld & rdy_q;
      assign dlv = (state_q != ST_EMPTY) & out_rdy;

      always_comb begin
        state_nxt = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        unique case (state_q)
          ST_EMPTY: begin
            if (acc) begin
              state_nxt = ST_ONE;
              load_main = 1'b1;
            end
          end
          ST_ONE: begin
            if (acc && dlv) begin
              // Main drains and refills in the same edge: no bubble.
              load_main = 1'b1;
            end else if (acc) begin
              state_nxt = ST_FULL;
              load_skid = 1'b1;
            end else if (dlv) begin
              state_nxt = ST_EMPTY;
            end
          end
          ST_FULL: begin
            // No accept is possible here because rdy_q is low.
            if (dlv) begin
              state_nxt = ST_ONE;
              move_skid = 1'b1;
            end
          end
          default: begin
            state_nxt = ST_EMPTY;
          end
        endcase
        // Ready is registered: it reflects whether skid will be free next cycle.
        rdy_nxt = (state_nxt != ST_FULL);
      end

      always_ff @(posedge axis_aclk or posedge axis_rst) begin
        if (axis_rst) begin
          state_q <= ST_EMPTY;
          rdy_q   <= 1'b0;
        end else begin
          state_q <= state_nxt;
          rdy_q   <= rdy_nxt;
        end
      end

      // Payload storage carries no reset; the valid flags above qualify it.
      always_ff @(posedge axis_aclk) begin
        if (move_skid) begin
          main_q <= skid_q;
        end else if (load_main) begin
          main_q <= in_dat;
        end
        if (load_skid) begin
          skid_q <= in_dat;
        end
      end

      assign out_vld = (state_q != ST_EMPTY);
      assign out_dat = main_q;
      assign in_rdy  = rdy_q;
    end else begin : g_pass
      assign out_vld = in_vld;
      assign out_dat = in_dat;
      assign in_rdy  = out_rdy;
    end

    assign dlv_vld = out_vld & out_rdy;

    // Counts packets leaving the block, so it advances on the delivering edge.
    always_ff @(posedge axis_aclk or posedge axis_rst) begin
      if (axis_rst) begin
        cnt_q <= '0;
      end else if (dlv_vld && out_dat.last) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign m_axis_tvalid[i]                           = out_vld;
    assign m_axis_tdata[i*DATA_W +: DATA_W]           = out_dat.dat;
    assign m_axis_tkeep[i*KEEP_W +: KEEP_W]           = out_dat.keep;
    assign m_axis_tlast[i]                            = out_dat.last;
    assign m_axis_tuser_size[i*USER_W +: USER_W]      = out_dat.size;
    assign m_axis_tuser_src[i*USER_W +: USER_W]       = out_dat.src;
    assign m_axis_tuser_dst[i*USER_W +: USER_W]       = out_dat.dst;
    assign pkt_cnt[i*CNT_W +: CNT_W]                  = cnt_q;
  end

endmodule

// File: tb/tb_axi_stream_if_m_reg_connector.sv
// Bench for axi_stream_if_m_reg_connector: scoreboard with randomized valid/ready.
// Latency: checks 1-cycle latency under full throughput; counters checked against a count model.
// Backpressure: randomized m_tready duty plus a directed 5-cycle stall on one channel.
module tb_axi_stream_if_m_reg_connector;
  localparam int N   = 4;
  localparam int DW  = 512;
  localparam int KW  = DW / 8;
  localparam int UW  = 16;
  localparam int CW  = 32;
  localparam int SDW = 32;
  localparam int SKW = SDW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  function automatic void timeout_fail(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout expected completion", nm);
  endfunction

  // ---------------- main DUT: 4 channels, registered ----------------
  axi_stream_if #(.DATA_W(DW), .USER_W(UW)) s_if [N] ();
  logic          s_vld [N];
  logic [DW-1:0] s_dat [N];
  logic [KW-1:0] s_keep [N];
  logic          s_last [N];
  logic [UW-1:0] s_sz [N];
  logic [UW-1:0] s_src [N];
  logic [UW-1:0] s_dst [N];
  logic          s_rdy [N];

  for (genvar g = 0; g < N; g++) begin : g_if
    assign s_if[g].valid     = s_vld[g];
    assign s_if[g].data      = s_dat[g];
    assign s_if[g].keep      = s_keep[g];
    assign s_if[g].last      = s_last[g];
    assign s_if[g].user_size = s_sz[g];
    assign s_if[g].user_src  = s_src[g];
    assign s_if[g].user_dst  = s_dst[g];
    assign s_rdy[g]          = s_if[g].ready;
  end

  logic [N-1:0]    m_vld;
  logic [N*DW-1:0] m_dat;
  logic [N*KW-1:0] m_keep;
  logic [N-1:0]    m_last;
  logic [N*UW-1:0] m_sz, m_src, m_dst;
  logic [N-1:0]    m_rdy;
  logic [N*CW-1:0] m_cnt;

  axi_stream_if_m_reg_connector #(
    .COUNTS(N), .DATA_W(DW), .USER_W(UW), .REG_EN(1), .CNT_W(CW)
  ) dut (
    .axis_aclk(clk), .axis_rst(rst), .s_axis(s_if),
    .m_axis_tvalid(m_vld), .m_axis_tdata(m_dat), .m_axis_tkeep(m_keep),
    .m_axis_tlast(m_last), .m_axis_tuser_size(m_sz), .m_axis_tuser_src(m_src),
    .m_axis_tuser_dst(m_dst), .m_axis_tready(m_rdy), .pkt_cnt(m_cnt)
  );

  // ---------------- wrap DUT: CNT_W=4 ----------------
  axi_stream_if #(.DATA_W(SDW), .USER_W(UW)) w_if [1] ();
  logic            w_mvld, w_mlast, w_trdy;
  logic [SDW-1:0]  w_mdat;
  logic [SKW-1:0]  w_mkeep;
  logic [UW-1:0]   w_msz, w_msrc, w_mdst;
  logic [3:0]      w_cnt;

  axi_stream_if_m_reg_connector #(
    .COUNTS(1), .DATA_W(SDW), .USER_W(UW), .REG_EN(1), .CNT_W(4)
  ) dut_wrap (
    .axis_aclk(clk), .axis_rst(rst), .s_axis(w_if),
    .m_axis_tvalid(w_mvld), .m_axis_tdata(w_mdat), .m_axis_tkeep(w_mkeep),
    .m_axis_tlast(w_mlast), .m_axis_tuser_size(w_msz), .m_axis_tuser_src(w_msrc),
    .m_axis_tuser_dst(w_mdst), .m_axis_tready(w_trdy), .pkt_cnt(w_cnt)
  );

  // ---------------- pass-through DUT: REG_EN=0 ----------------
  axi_stream_if #(.DATA_W(SDW), .USER_W(UW)) p_if [1] ();
  logic            p_mvld, p_mlast, p_trdy;
  logic [SDW-1:0]  p_mdat;
  logic [SKW-1:0]  p_mkeep;
  logic [UW-1:0]   p_msz, p_msrc, p_mdst;
  logic [7:0]      p_cnt;

  axi_stream_if_m_reg_connector #(
    .COUNTS(1), .DATA_W(SDW), .USER_W(UW), .REG_EN(0), .CNT_W(8)
  ) dut_pass (
    .axis_aclk(clk), .axis_rst(rst), .s_axis(p_if),
    .m_axis_tvalid(p_mvld), .m_axis_tdata(p_mdat), .m_axis_tkeep(p_mkeep),
    .m_axis_tlast(p_mlast), .m_axis_tuser_size(p_msz), .m_axis_tuser_src(p_msrc),
    .m_axis_tuser_dst(p_mdst), .m_axis_tready(p_trdy), .pkt_cnt(p_cnt)
  );

  // ---------------- reference model / scoreboard ----------------
  typedef struct {
    logic [DW-1:0] dat;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] sz;
    logic [UW-1:0] src;
    logic [UW-1:0] dst;
    int            acc_cyc;
  } beat_t;

  beat_t        exp_q [N][$];
  logic [CW-1:0] model_cnt [N];
  bit           strict [N];
  int           stalls [N];
  int           rdy_duty [N];
  bit           rdy_force_lo [N];

  function automatic beat_t rand_beat(input bit last);
    beat_t b;
    for (int w = 0; w < DW / 32; w++) b.dat[w*32 +: 32] = $urandom;
    for (int w = 0; w < KW / 32; w++) b.keep[w*32 +: 32] = $urandom;
    b.last = last;
    b.sz = UW'($urandom);
    b.src = UW'($urandom);
    b.dst = UW'($urandom);
    b.acc_cyc = 0;
    return b;
  endfunction

  // Presents one beat (after idle cycles drawn from duty) and holds it until accepted.
  task automatic send_beat(input int c, input beat_t b0, input int duty, output bit stalled);
    beat_t b;
    bit acc_now;
    int guard;
    b = b0;
    while ($urandom_range(0, 99) >= duty) begin
      s_vld[c] = 1'b0;
      @(posedge clk); #1;
    end
    s_vld[c] = 1'b1; s_dat[c] = b.dat; s_keep[c] = b.keep; s_last[c] = b.last;
    s_sz[c] = b.sz; s_src[c] = b.src; s_dst[c] = b.dst;
    stalled = 1'b0;
    guard = 0;
    acc_now = 1'b0;
    while (!acc_now && guard < 2000) begin
      @(negedge clk);
      acc_now = s_rdy[c];
      @(posedge clk); #1;
      if (!acc_now) begin
        stalled = 1'b1;
        guard++;
      end
    end
    s_vld[c] = 1'b0;
    if (acc_now) begin
      b.acc_cyc = cyc;
      exp_q[c].push_back(b);
    end else begin
      timeout_fail($sformatf("ch%0d_send", c));
    end
  endtask

  task automatic send_pkt(input int c, input int len, input int duty);
    bit st;
    for (int i = 0; i < len; i++) begin
      send_beat(c, rand_beat(i == len - 1), duty, st);
      if (st) stalls[c]++;
    end
  endtask

  task automatic rand_chan(input int c, input int npk);
    int d;
    for (int p = 0; p < npk; p++) begin
      case ($urandom_range(0, 2))
        0: d = 30;
        1: d = 70;
        default: d = 100;
      endcase
      send_pkt(c, $urandom_range(1, 17), d);
    end
  endtask

  task automatic drain(input int limit);
    int g;
    bit busy;
    g = 0;
    busy = 1'b1;
    while (busy && g < limit) begin
      busy = 1'b0;
      for (int c = 0; c < N; c++) if (exp_q[c].size() != 0) busy = 1'b1;
      if (busy) begin
        @(posedge clk);
        g++;
      end
    end
    if (busy) timeout_fail("drain");
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready generator.
  initial begin
    m_rdy = '0;
    forever begin
      @(posedge clk); #1;
      for (int c = 0; c < N; c++)
        m_rdy[c] = !rdy_force_lo[c] && ($urandom_range(0, 99) < rdy_duty[c]);
    end
  end

  // Monitor: pops the expected beat whenever a delivery is about to happen.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      for (int c = 0; c < N; c++) begin
        if (m_vld[c] && m_rdy[c]) begin
          if (exp_q[c].size() == 0) begin
            chk($sformatf("ch%0d_unexpected_beat", c), 512'(1), 512'(0));
          end else begin
            e = exp_q[c].pop_front();
            chk($sformatf("ch%0d_data", c), 512'(m_dat[c*DW +: DW]), 512'(e.dat));
            chk($sformatf("ch%0d_side", c),
                512'({m_keep[c*KW +: KW], m_last[c], m_sz[c*UW +: UW], m_src[c*UW +: UW], m_dst[c*UW +: UW]}),
                512'({e.keep, e.last, e.sz, e.src, e.dst}));
            chk($sformatf("ch%0d_pkt_cnt", c), 512'(m_cnt[c*CW +: CW]), 512'(model_cnt[c]));
            if (strict[c]) chk($sformatf("ch%0d_latency", c), 512'(cyc + 1 - e.acc_cyc), 512'(1));
            if (e.last) model_cnt[c] = model_cnt[c] + 1;
          end
        end
      end
    end
  end

  // Directed stall of channel 1 for five cycles while it is streaming.
  task automatic stall_ch1();
    int extra, lows;
    extra = 0;
    lows = 0;
    repeat (4) @(negedge clk);
    rdy_force_lo[1] = 1'b1;
    @(posedge clk); #2;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (s_vld[1] && s_rdy[1]) extra++;
      if (!s_rdy[1]) lows++;
      if (k == 4) rdy_force_lo[1] = 1'b0;
    end
    chk("bp_extra_beats", 512'(extra), 512'(1));
    chk("bp_ready_low_cycles", 512'(lows), 512'(4));
  endtask

  initial begin
    bit st;
    int pmodel;
    logic pv, pl, pr;
    logic [SDW-1:0] pd;
    logic [SKW-1:0] pk;
    logic [UW-1:0] pz, ps, pt;

    for (int c = 0; c < N; c++) begin
      s_vld[c] = 1'b0; s_dat[c] = '0; s_keep[c] = '0; s_last[c] = 1'b0;
      s_sz[c] = '0; s_src[c] = '0; s_dst[c] = '0;
      model_cnt[c] = '0; strict[c] = 1'b0; stalls[c] = 0;
      rdy_duty[c] = 100; rdy_force_lo[c] = 1'b0;
    end
    w_if[0].valid = 1'b0; w_if[0].data = '0; w_if[0].keep = '0; w_if[0].last = 1'b0;
    w_if[0].user_size = '0; w_if[0].user_src = '0; w_if[0].user_dst = '0; w_trdy = 1'b1;
    p_if[0].valid = 1'b0; p_if[0].data = '0; p_if[0].keep = '0; p_if[0].last = 1'b0;
    p_if[0].user_size = '0; p_if[0].user_src = '0; p_if[0].user_dst = '0; p_trdy = 1'b0;

    // Reset state and first ready edge.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_vld", 512'(m_vld), 512'(0));
    chk("rst_pkt_cnt", 512'(m_cnt), 512'(0));
    for (int c = 0; c < N; c++) chk($sformatf("rst_s_rdy%0d", c), 512'(s_rdy[c]), 512'(0));
    rst = 1'b0;
    #1;
    chk("rel_s_rdy0_before_edge", 512'(s_rdy[0]), 512'(0));
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) chk($sformatf("rel_s_rdy%0d", c), 512'(s_rdy[c]), 512'(1));

    // Streaming: one 64-beat packet per channel at full rate.
    for (int c = 0; c < N; c++) strict[c] = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) begin
      automatic int cc = c;
      fork send_pkt(cc, 64, 100); join_none
    end
    wait fork;
    drain(1000);
    for (int c = 0; c < N; c++) begin
      chk($sformatf("stream_stalls%0d", c), 512'(stalls[c]), 512'(0));
      chk($sformatf("stream_cnt%0d", c), 512'(m_cnt[c*CW +: CW]), 512'(1));
    end

    // Backpressure on channel 1 only; others keep strict latency.
    strict[1] = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) begin
      automatic int cc = c;
      fork send_pkt(cc, 32, 100); join_none
    end
    fork stall_ch1(); join_none
    wait fork;
    drain(1000);
    for (int c = 0; c < N; c++) chk($sformatf("bp_cnt%0d", c), 512'(m_cnt[c*CW +: CW]), 512'(2));

    // Random valid/ready: 250 packets per channel, 1000 in total.
    for (int c = 0; c < N; c++) strict[c] = 1'b0;
    rdy_duty[0] = 30; rdy_duty[1] = 70; rdy_duty[2] = 100; rdy_duty[3] = 70;
    @(posedge clk); #1;
    for (int c = 0; c < N; c++) begin
      automatic int cc = c;
      fork rand_chan(cc, 250); join_none
    end
    wait fork;
    drain(20000);
    begin
      int tot;
      tot = 0;
      for (int c = 0; c < N; c++) begin
        chk($sformatf("rand_cnt%0d", c), 512'(m_cnt[c*CW +: CW]), 512'(252));
        tot += int'(m_cnt[c*CW +: CW]) - 2;
      end
      chk("rand_total_pkts", 512'(tot), 512'(1000));
    end

    // Reset with two beats buffered on channel 0.
    for (int c = 0; c < N; c++) rdy_duty[c] = 0;
    repeat (2) @(posedge clk);
    #1;
    send_beat(0, rand_beat(1'b1), 100, st);
    send_beat(0, rand_beat(1'b1), 100, st);
    chk("pre_rst_full_s_rdy", 512'(s_rdy[0]), 512'(0));
    chk("pre_rst_full_m_vld", 512'(m_vld[0]), 512'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_m_vld", 512'(m_vld), 512'(0));
    chk("mid_rst_s_rdy0", 512'(s_rdy[0]), 512'(0));
    chk("mid_rst_pkt_cnt", 512'(m_cnt), 512'(0));
    for (int c = 0; c < N; c++) begin
      exp_q[c].delete();
      model_cnt[c] = '0;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rel2_s_rdy0_before_edge", 512'(s_rdy[0]), 512'(0));
    @(posedge clk); #1;
    chk("rel2_s_rdy0", 512'(s_rdy[0]), 512'(1));

    // Counter wrap on the CNT_W=4 instance; last=0 beats must not count.
    for (int i = 0; i < 3; i++) begin
      w_if[0].valid = 1'b1; w_if[0].last = 1'b0; w_if[0].data = SDW'(i);
      @(posedge clk); #1;
    end
    w_if[0].valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_no_last_cnt", 512'(w_cnt), 512'(0));
    for (int i = 0; i < 17; i++) begin
      w_if[0].valid = 1'b1; w_if[0].last = 1'b1; w_if[0].data = SDW'(i);
      @(posedge clk); #1;
    end
    w_if[0].valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_cnt", 512'(w_cnt), 512'(1));

    // Pass-through: outputs mirror inputs in the same cycle.
    pmodel = 0;
    for (int i = 0; i < 30; i++) begin
      pv = 1'($urandom); pl = 1'($urandom); pr = 1'($urandom);
      pd = $urandom; pk = SKW'($urandom);
      pz = UW'($urandom); ps = UW'($urandom); pt = UW'($urandom);
      p_if[0].valid = pv; p_if[0].last = pl; p_if[0].data = pd; p_if[0].keep = pk;
      p_if[0].user_size = pz; p_if[0].user_src = ps; p_if[0].user_dst = pt; p_trdy = pr;
      #1;
      chk("pass_payload", 512'({p_mvld, p_mdat, p_mkeep, p_mlast, p_msz, p_msrc, p_mdst}),
          512'({pv, pd, pk, pl, pz, ps, pt}));
      chk("pass_ready", 512'(p_if[0].ready), 512'(pr));
      if (pv && pr && pl) pmodel++;
      @(posedge clk); #1;
    end
    p_if[0].valid = 1'b0;
    @(posedge clk); #1;
    chk("pass_cnt", 512'(p_cnt), 512'(pmodel));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_stream_if_m_reg_connector.md
# axi_stream_if_m_reg_connector

Registered successor of the interface-to-flat AXI-Stream master connector. It converts an array of `axi_stream_if` slave interfaces into flat, concatenated master-side AXI-Stream vectors. Each channel passes through a full-throughput two-entry skid buffer, which breaks the combinational valid/ready path between user-plugin logic and the shell boundary. Each channel also keeps a packet counter. It sits at the egress edge of a user plugin, in front of the shell's flat AXI-Stream ports.

## Interface
- `COUNTS`, 1: number of channels; legal range 1..16.
- `DATA_W`, 512: tdata width per channel; multiple of 8; must equal the interface data width.
- `USER_W`, 16: width of each tuser field (size/src/dst) per channel.
- `REG_EN`, 1: 1 = skid buffer per channel; 0 = combinational pass-through, same as the previous generation (counters still present).
- `CNT_W`, 32: packet counter width per channel.

Ports:
- `axis_aclk`  in  1  clock for all logic.
- `axis_rst`  in  1  reset, asynchronous and active-high; one clock, no other reset.
- `s_axis[COUNTS]`  axi_stream_if.slave  -  per-channel input. Fields: valid, data[DATA_W], keep[DATA_W/8], last, user_size/src/dst[USER_W], ready (output).
- `m_axis_tvalid`  out  COUNTS  per-channel valid.
- `m_axis_tdata`  out  DATA_W*COUNTS  channel i at [i*DATA_W +: DATA_W].
- `m_axis_tkeep`  out  DATA_W/8*COUNTS  channel i at [i*DATA_W/8 +: DATA_W/8].
- `m_axis_tlast`  out  COUNTS  per-channel last.
- `m_axis_tuser_size`, `m_axis_tuser_src`, `m_axis_tuser_dst`  out  USER_W*COUNTS each  channel i at [i*USER_W +: USER_W].
- `m_axis_tready`  in  COUNTS  per-channel ready.
- `pkt_cnt`  out  CNT_W*COUNTS  packets delivered per channel; channel i at [i*CNT_W +: CNT_W].

## Operation
- Channels are fully independent; there is no cross-channel arbitration or coupling.
- Payload bundle per channel: {data, keep, last, user_size, user_src, user_dst}. The bundle is transferred intact and in order. No field is modified.
- Beat accepted: `s.valid & s.ready`. Beat delivered: `m_tvalid & m_tready`.

Skid buffer (REG_EN=1), per channel, holds a main register (drives m_axis) and a skid register. States:
- EMPTY: main and skid invalid. s.ready=1.
  - Accept → ONE.
- ONE: main valid. s.ready=1.
  - Accept without deliver → FULL; the beat goes to skid.
  - Accept with deliver → ONE; the new beat goes to main.
  - Deliver without accept → EMPTY.
- FULL: both valid. s.ready=0.
  - Deliver → ONE; skid moves to main.
- s.ready is a registered output: it equals NOT skid-valid.
- Payload registers have no reset. Only valid and ready flags are reset.

Pass-through (REG_EN=0):
- m fields = s fields, and s.ready = m_tready, combinationally.

Packet counter:
- Increments by 1 on each delivered beat with tlast=1.
- Wraps modulo 2^CNT_W.
- Resets to 0.

AXI-Stream rules:
- Once asserted, m_tvalid stays high and the bundle stays stable until delivered.
- m_tvalid never depends combinationally on m_tready (REG_EN=1).

## Timing
Reset values, while axis_rst is high:
- m_axis_tvalid=0, s.ready=0, pkt_cnt=0.
- States are EMPTY.
- m tdata/tkeep/tuser/tlast: don't-care (unreset).

After reset:
- s.ready rises on the first axis_aclk edge after axis_rst deasserts.

Latency and throughput (REG_EN=1):
- Latency is 1 cycle: a beat accepted at edge N is valid on m_axis after edge N.
- Sustained throughput is 1 beat/cycle with m_tready held high.

Backpressure:
- m_tready drops with main valid: at most one more beat is accepted (into skid).
- s.ready then deasserts on the following edge.
- m_tready rising in FULL: main delivers and skid moves to main that cycle. s.ready reasserts the next cycle.

Simultaneous events:
- Accept and deliver in the same cycle in ONE: stays ONE, no bubble.

Counter timing:
- pkt_cnt updates on the edge of the delivering beat and is visible the next cycle.

Reset mid-packet:
- In-flight beats in main and skid are discarded. Valid flags clear immediately (asynchronous).
- No partial-packet recovery; upstream must also reset.

REG_EN=0:
- Latency is 0. Only pkt_cnt is registered.

## Test plan
- **Reset:** assert axis_rst mid-stream with 2 beats buffered → m_tvalid=0, s.ready=0, pkt_cnt=0 immediately. s.ready=1 one cycle after release.
- **Streaming:** COUNTS=4, 64-beat packets on all channels, m_tready=1 → each beat appears 1 cycle later, 1 beat/cycle, bit-exact lane placement (channel 2 data at [1535:1024]); pkt_cnt=1 per channel.
- **Backpressure:** drop m_tready on channel 1 for 5 cycles while s.valid=1 → exactly one extra beat accepted, then s.ready=0. No loss or duplication after release; other channels unaffected.
- **Random valid/ready:** randomized valid/ready at 30/70/100% duty, 1000 packets of 1..17 beats → scoreboard matches order and all tuser/tkeep fields; pkt_cnt=1000.
- **Counter wrap:** CNT_W=4, 17 single-beat packets → pkt_cnt=1. Beats with last=0 never increment it.
- **Pass-through:** REG_EN=0 → m outputs mirror s inputs in the same cycle, and s.ready mirrors m_tready.
